// File: rtl/power_window_monitor.sv
// rtl/power_window_monitor.sv - pipelined masked power total, window average, peak, energy and alarm
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   monitor_en        accepts new samples when high
//   clear_stats       synchronous clear of all statistics and in-flight samples
//   sample_valid      domain_power carries a sample this cycle
//   domain_power      flat per-domain power, domain d at [d*PWR_W +: PWR_W]
//   domain_mask       1 = domain contributes to the total
//   limit_hi/lo       alarm assert / deassert thresholds
//   total_power       last accepted masked total
//   avg_power         sliding-window average (0 until the window is full)
//   peak_power        largest total since clear
//   energy_acc        saturating sum of totals
//   window_full       window holds 2^WIN_LOG2 samples
//   over_limit        alarm state
//   alarm_pulse       one-cycle pulse on entry to the alarm state

module power_window_monitor #(
    parameter int NUM_DOMAINS = 8,
    parameter int PWR_W       = 16,
    parameter int WIN_LOG2    = 4,
    parameter int ENERGY_W    = 40,
    localparam int TOT_W      = PWR_W + $clog2(NUM_DOMAINS),
    localparam int SUM_W      = TOT_W + WIN_LOG2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         monitor_en,
    input  logic                         clear_stats,
    input  logic                         sample_valid,
    input  logic [NUM_DOMAINS*PWR_W-1:0] domain_power,
    input  logic [NUM_DOMAINS-1:0]       domain_mask,
    input  logic [TOT_W-1:0]             limit_hi,
    input  logic [TOT_W-1:0]             limit_lo,
    output logic [TOT_W-1:0]             total_power,
    output logic [TOT_W-1:0]             avg_power,
    output logic [TOT_W-1:0]             peak_power,
    output logic [ENERGY_W-1:0]          energy_acc,
    output logic                         window_full,
    output logic                         over_limit,
    output logic                         alarm_pulse
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam logic [WIN_LOG2:0] DEPTH_CNT = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic {
        ST_NORMAL,
        ST_OVER
    } alarm_state_t;

    // Stage 1 state
    logic                   s1_valid;
    logic [TOT_W-1:0]       masked_sum;
    logic                   accept;

    // Stage 2 state
    logic [TOT_W-1:0]       win_buf [DEPTH];
    logic [WIN_LOG2-1:0]    wr_ptr;
    logic [WIN_LOG2:0]      count;
    logic [SUM_W-1:0]       running_sum;
    logic [SUM_W-1:0]       sum_next;
    logic [TOT_W-1:0]       evicted;
    logic [WIN_LOG2:0]      count_next;
    logic [ENERGY_W:0]      energy_add;

    // Stage 3 state
    alarm_state_t           state;

    assign accept = sample_valid && monitor_en && !clear_stats;

    always_comb begin
        masked_sum = '0;
        for (int d = 0; d < NUM_DOMAINS; d++) begin
            if (domain_mask[d]) begin
                masked_sum = masked_sum + TOT_W'(domain_power[d*PWR_W +: PWR_W]);
            end
        end
    end

    // Stage 1: register the masked total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_power <= '0;
            s1_valid    <= 1'b0;
        end else if (clear_stats) begin
            total_power <= '0;
            s1_valid    <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                total_power <= masked_sum;
            end
        end
    end

    assign window_full = (count == DEPTH_CNT);

    // Once full, the slot under wr_ptr holds the oldest sample, so it leaves
    // the running sum in the same update that the new sample enters it.
    always_comb begin
        evicted    = window_full ? win_buf[wr_ptr] : '0;
        sum_next   = running_sum + SUM_W'(total_power) - SUM_W'(evicted);
        count_next = window_full ? count : count + (WIN_LOG2+1)'(1);
        energy_add = {1'b0, energy_acc} + (ENERGY_W+1)'(total_power);
    end

    // Buffer contents are never cleared; count keeps stale entries out of the sum.
    always_ff @(posedge clk) begin
        if (s1_valid && !clear_stats) begin
            win_buf[wr_ptr] <= total_power;
        end
    end

    // Stage 2: window, peak and energy statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            count       <= '0;
            running_sum <= '0;
            avg_power   <= '0;
            peak_power  <= '0;
            energy_acc  <= '0;
        end else if (clear_stats) begin
            wr_ptr      <= '0;
            count       <= '0;
            running_sum <= '0;
            avg_power   <= '0;
            peak_power  <= '0;
            energy_acc  <= '0;
        end else if (s1_valid) begin
            wr_ptr      <= wr_ptr + WIN_LOG2'(1);
            count       <= count_next;
            running_sum <= sum_next;
            avg_power   <= (count_next == DEPTH_CNT) ? sum_next[SUM_W-1:WIN_LOG2] : '0;
            if (total_power > peak_power) begin
                peak_power <= total_power;
            end
            // A carry out of the top bit means the sum passed the maximum.
            energy_acc  <= energy_add[ENERGY_W] ? '1 : energy_add[ENERGY_W-1:0];
        end
    end

    // Stage 3: hysteresis alarm on the registered average
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_NORMAL;
            over_limit  <= 1'b0;
            alarm_pulse <= 1'b0;
        end else if (clear_stats) begin
            state       <= ST_NORMAL;
            over_limit  <= 1'b0;
            alarm_pulse <= 1'b0;
        end else begin
            alarm_pulse <= 1'b0;
            case (state)
                ST_NORMAL: begin
                    if (window_full && (avg_power > limit_hi)) begin
                        state       <= ST_OVER;
                        over_limit  <= 1'b1;
                        alarm_pulse <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (avg_power < limit_lo) begin
                        state      <= ST_NORMAL;
                        over_limit <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_NORMAL;
                    over_limit <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_window_monitor.sv
// tb/tb_power_window_monitor.sv - self-checking bench for power_window_monitor

module tb_power_window_monitor;

    localparam int ND = 4;
    localparam int PW = 16;
    localparam int WL = 2;
    localparam int EW = 20;
    localparam int TW = 18;
    localparam longint E_MAX = (64'd1 << EW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             monitor_en;
    logic             clear_stats;
    logic             sample_valid;
    logic [ND*PW-1:0] domain_power;
    logic [ND-1:0]    domain_mask;
    logic [TW-1:0]    limit_hi;
    logic [TW-1:0]    limit_lo;
    logic [TW-1:0]    total_power;
    logic [TW-1:0]    avg_power;
    logic [TW-1:0]    peak_power;
    logic [EW-1:0]    energy_acc;
    logic             window_full;
    logic             over_limit;
    logic             alarm_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    // Reference model state
    int     m_total;
    bit     m_s1;
    int     win[$];
    int     m_avg;
    int     m_peak;
    longint m_energy;
    bit     m_full;
    bit     m_over;
    bit     m_pulse;

    power_window_monitor #(
        .NUM_DOMAINS(ND),
        .PWR_W      (PW),
        .WIN_LOG2   (WL),
        .ENERGY_W   (EW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .monitor_en  (monitor_en),
        .clear_stats (clear_stats),
        .sample_valid(sample_valid),
        .domain_power(domain_power),
        .domain_mask (domain_mask),
        .limit_hi    (limit_hi),
        .limit_lo    (limit_lo),
        .total_power (total_power),
        .avg_power   (avg_power),
        .peak_power  (peak_power),
        .energy_acc  (energy_acc),
        .window_full (window_full),
        .over_limit  (over_limit),
        .alarm_pulse (alarm_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_total  = 0;
        m_s1     = 0;
        win.delete();
        m_avg    = 0;
        m_peak   = 0;
        m_energy = 0;
        m_full   = 0;
        m_over   = 0;
        m_pulse  = 0;
    endtask

    // One clock edge of behaviour; later stages use values from before the edge.
    task automatic model_edge();
        int s;
        s = 0;
        if (rst || clear_stats) begin
            model_reset();
            return;
        end
        if (!m_over) begin
            m_pulse = m_full && (m_avg > int'(limit_hi));
            if (m_pulse) m_over = 1;
        end else begin
            m_pulse = 0;
            if (m_avg < int'(limit_lo)) m_over = 0;
        end
        if (m_s1) begin
            win.push_back(m_total);
            if (win.size() > (1 << WL)) void'(win.pop_front());
            m_full = (win.size() == (1 << WL));
            foreach (win[i]) s += win[i];
            m_avg = m_full ? s / (1 << WL) : 0;
            if (m_total > m_peak) m_peak = m_total;
            m_energy = m_energy + m_total;
            if (m_energy > E_MAX) m_energy = E_MAX;
        end
        m_s1 = sample_valid && monitor_en;
        if (m_s1) begin
            m_total = 0;
            for (int d = 0; d < ND; d++) begin
                if (domain_mask[d]) m_total += int'(domain_power[d*PW +: PW]);
            end
        end
    endtask

    task automatic check_all();
        check("total_power", total_power, m_total);
        check("avg_power",   avg_power,   m_avg);
        check("peak_power",  peak_power,  m_peak);
        check("energy_acc",  energy_acc,  m_energy);
        check("window_full", window_full, m_full);
        check("over_limit",  over_limit,  m_over);
        check("alarm_pulse", alarm_pulse, m_pulse);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (alarm_pulse === 1'b1) pulses++;
    endtask

    task automatic send(input int v);
        domain_power = {48'd0, 16'(v)};
        domain_mask  = 4'b0001;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    initial begin
        monitor_en   = 1'b1;
        clear_stats  = 1'b0;
        sample_valid = 1'b0;
        domain_power = '0;
        domain_mask  = '1;
        limit_hi     = '1;
        limit_lo     = '0;
        model_reset();

        // Reset held, then released with no samples
        tick();
        tick();
        rst = 1'b0;
        idle(2);

        // Masked sum
        domain_power = {16'd400, 16'd300, 16'd200, 16'd100};
        domain_mask  = 4'b1011;
        sample_valid = 1'b1;
        tick();
        check("mask_1011_total", total_power, 700);
        domain_mask = 4'b0000;
        tick();
        check("mask_0000_total", total_power, 0);
        idle(3);

        // Window average and peak
        do_clear();
        send(100); send(200); send(300); send(400);
        idle(1);
        check("win_first_avg", avg_power, 250);
        check("win_first_full", window_full, 1);
        send(800);
        idle(1);
        check("win_slide_avg", avg_power, 425);
        check("win_peak", peak_power, 800);
        idle(2);

        // Hysteresis
        do_clear();
        limit_hi = 18'd500;
        limit_lo = 18'd300;
        pulses = 0;
        repeat (4) send(600);
        idle(3);
        check("hyst_over_600", over_limit, 1);
        repeat (4) send(400);
        idle(3);
        check("hyst_hold_400", over_limit, 1);
        repeat (4) send(300);
        idle(3);
        check("hyst_hold_300_eq", over_limit, 1);
        repeat (4) send(250);
        idle(3);
        check("hyst_normal_250", over_limit, 0);
        check("hyst_pulse_count", pulses, 1);
        limit_hi = '1;
        limit_lo = '0;

        // Energy saturation
        do_clear();
        repeat (16) send(65535);
        idle(2);
        check("energy_16", energy_acc, 1048560);
        send(65535);
        idle(2);
        check("energy_17_sat", energy_acc, 1048575);
        repeat (3) send(65535);
        idle(2);
        check("energy_hold_sat", energy_acc, 1048575);

        // Clear coincident with a sample, then disabled sampling
        domain_power = {48'd0, 16'd65535};
        domain_mask  = 4'b0001;
        sample_valid = 1'b1;
        clear_stats  = 1'b1;
        tick();
        clear_stats  = 1'b0;
        sample_valid = 1'b0;
        check("clr_total", total_power, 0);
        check("clr_peak", peak_power, 0);
        check("clr_energy", energy_acc, 0);
        check("clr_full", window_full, 0);
        idle(2);
        check("clr_dropped_energy", energy_acc, 0);
        send(500);
        idle(2);
        check("en_base_energy", energy_acc, 500);
        monitor_en = 1'b0;
        repeat (5) send(1000);
        idle(2);
        check("en_off_energy", energy_acc, 500);
        monitor_en = 1'b1;

        // Asynchronous reset mid-pipeline
        send(123);
        send(456);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_total", total_power, 0);
        check("rst_async_energy", energy_acc, 0);
        check("rst_async_peak", peak_power, 0);
        model_reset();
        tick();
        rst = 1'b0;
        idle(3);

        // Randomized traffic
        limit_hi = 18'd70000;
        limit_lo = 18'd50000;
        repeat (400) begin
            clear_stats  = ($urandom_range(0, 59) == 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            monitor_en   = ($urandom_range(0, 7) != 0);
            domain_mask  = 4'($urandom);
            domain_power = {$urandom, $urandom};
            if ($urandom_range(0, 31) == 0) begin
                limit_hi = 18'($urandom_range(0, 150000));
                limit_lo = 18'($urandom_range(0, 150000));
            end
            tick();
        end
        clear_stats  = 1'b0;
        sample_valid = 1'b0;
        monitor_en   = 1'b1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
